// File: rtl/riscv_pkg.sv
// Shared types for the memory-port arbiter: FSM states, bus owner and the
// default bound on consecutive data grants while a fetch waits.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-outstanding memory bus.
// Data wins by default; a waiting fetch wins once the data streak reaches STARVE_LIMIT.
module mem_port_arbiter
   import riscv_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   input  logic        i_flush,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic        d_we,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        bus_req,
   output logic [31:0] bus_addr,
   output logic        bus_we,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   output logic        busy
);

   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   arb_state_e  state_q;
   owner_e      owner_q;
   logic [SW-1:0] streak_q, streak_d;
   logic        kill_q, kill_d, kill_now_s;
   logic        fetch_win_s, i_gnt_s, d_gnt_s;
   logic        bus_req_q, bus_we_q;
   logic [31:0] bus_addr_q, bus_wdata_q;
   logic [3:0]  bus_wstrb_q;
   logic        i_rvalid_q, d_rvalid_q;
   logic [31:0] i_rdata_q, d_rdata_q;

   // Grant selection: only in IDLE and never while reset is applied.
   always_comb begin
      fetch_win_s = i_req && (!d_req || (streak_q == LIMIT));
      if (!rst && (state_q == IDLE)) begin
         i_gnt_s = fetch_win_s;
         d_gnt_s = d_req && !fetch_win_s;
      end else begin
         i_gnt_s = 1'b0;
         d_gnt_s = 1'b0;
      end
   end

   // Saturating count of data grants taken while a fetch was waiting.
   always_comb begin
      streak_d = streak_q;
      if (i_gnt_s) begin
         streak_d = {SW{1'b0}};
      end else if (d_gnt_s) begin
         if (!i_req) begin
            streak_d = {SW{1'b0}};
         end else if (streak_q >= LIMIT) begin
            streak_d = LIMIT;
         end else begin
            streak_d = streak_q + SW'(1'b1);
         end
      end else begin
         streak_d = streak_q;
      end
   end

   // Kill flag: a flush during a fetch lets the bus finish but hides the response.
   always_comb begin
      kill_now_s = kill_q || (i_flush && (owner_q == OWN_I));
      case (state_q)
         IDLE:     kill_d = i_gnt_s && i_flush;
         ISSUE:    kill_d = kill_now_s;
         WAIT_RSP: kill_d = bus_rvalid ? 1'b0 : kill_now_s;
         default:  kill_d = 1'b0;
      endcase
   end

   // Transaction FSM with all bus and response outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_I;
         streak_q    <= {SW{1'b0}};
         kill_q      <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_addr_q  <= 32'h0000_0000;
         bus_we_q    <= 1'b0;
         bus_wdata_q <= 32'h0000_0000;
         bus_wstrb_q <= 4'b0000;
         i_rvalid_q  <= 1'b0;
         d_rvalid_q  <= 1'b0;
         i_rdata_q   <= 32'h0000_0000;
         d_rdata_q   <= 32'h0000_0000;
      end else begin
         streak_q   <= streak_d;
         kill_q     <= kill_d;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_gnt_s || d_gnt_s) begin
                  owner_q     <= i_gnt_s ? OWN_I : OWN_D;
                  bus_addr_q  <= i_gnt_s ? i_addr : d_addr;
                  bus_we_q    <= d_gnt_s && d_we;
                  bus_wdata_q <= i_gnt_s ? 32'h0000_0000 : d_wdata;
                  bus_wstrb_q <= i_gnt_s ? 4'b0000 : d_wstrb;
                  bus_req_q   <= 1'b1;
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus_gnt) begin
                  bus_req_q <= 1'b0;
                  state_q   <= WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               if (bus_rvalid) begin
                  if (owner_q == OWN_D) begin
                     d_rdata_q  <= bus_rdata;
                     d_rvalid_q <= 1'b1;
                  end else if (!kill_now_s) begin
                     i_rdata_q  <= bus_rdata;
                     i_rvalid_q <= 1'b1;
                  end
                  state_q <= IDLE;
               end
            end
            default: begin
               bus_req_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign i_gnt     = i_gnt_s;
   assign d_gnt     = d_gnt_s;
   assign bus_req   = bus_req_q;
   assign bus_addr  = bus_addr_q;
   assign bus_we    = bus_we_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_wstrb = bus_wstrb_q;
   assign i_rvalid  = i_rvalid_q;
   assign i_rdata   = i_rdata_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int LIM = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, i_req, i_flush, d_req, d_we, bus_gnt, bus_rvalid;
   logic [31:0] i_addr, d_addr, d_wdata, bus_rdata;
   logic [3:0]  d_wstrb;
   logic        i_gnt, i_rvalid, d_gnt, d_rvalid, bus_req, bus_we, busy;
   logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;

   mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
      .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we),
      .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
      .busy(busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: one outstanding transaction record plus the fetch-starvation count.
   bit          m_busy, m_acc, m_own_d, m_killed, m_we, m_rv_i, m_rv_d;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_wstrb;
   int          m_streak;
   bit          e_ig, e_dg;
   string       glog;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare();
      e_ig = !rst && !m_busy && i_req && (!d_req || (m_streak == LIM));
      e_dg = !rst && !m_busy && d_req && !e_ig;
      chk1("i_gnt", i_gnt, e_ig);
      chk1("d_gnt", d_gnt, e_dg);
      chk1("bus_req", bus_req, m_busy && !m_acc);
      chk1("busy", busy, m_busy);
      chk1("i_rvalid", i_rvalid, m_rv_i);
      chk1("d_rvalid", d_rvalid, m_rv_d);
      if (m_busy && !m_acc) begin
         chk32("bus_addr", bus_addr, m_addr);
         chk1("bus_we", bus_we, m_we);
         chk32("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, m_wstrb});
         if (m_own_d) chk32("bus_wdata", bus_wdata, m_wdata);
      end
      if (m_rv_i) chk32("i_rdata", i_rdata, m_rdata);
      if (m_rv_d && !m_we) chk32("d_rdata", d_rdata, m_rdata);
      if (i_gnt === 1'b1) glog = {glog, "I"};
      if (d_gnt === 1'b1) glog = {glog, "D"};
   endtask

   task automatic update();
      if (rst) begin
         m_busy = 1'b0; m_acc = 1'b0; m_killed = 1'b0; m_streak = 0;
         m_rv_i = 1'b0; m_rv_d = 1'b0;
      end else begin
         m_rv_i = 1'b0;
         m_rv_d = 1'b0;
         if (!m_busy) begin
            if (e_ig) begin
               m_busy = 1'b1; m_acc = 1'b0; m_own_d = 1'b0; m_addr = i_addr;
               m_we = 1'b0; m_wstrb = 4'b0000; m_wdata = 32'd0;
               m_killed = i_flush; m_streak = 0;
            end else if (e_dg) begin
               m_busy = 1'b1; m_acc = 1'b0; m_own_d = 1'b1; m_addr = d_addr;
               m_we = d_we; m_wstrb = d_wstrb; m_wdata = d_wdata; m_killed = 1'b0;
               m_streak = i_req ? ((m_streak + 1 > LIM) ? LIM : m_streak + 1) : 0;
            end
         end else begin
            if (!m_own_d && i_flush) m_killed = 1'b1;
            if (!m_acc) begin
               m_acc = bus_gnt;
            end else if (bus_rvalid) begin
               m_busy  = 1'b0;
               m_rdata = bus_rdata;
               if (m_own_d) m_rv_d = 1'b1;
               else         m_rv_i = !m_killed;
            end
         end
      end
   endtask

   task automatic step();
      #1;
      compare();
      update();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; i_req = 1'b0; i_addr = 32'd0; i_flush = 1'b0;
      d_req = 1'b0; d_addr = 32'd0; d_we = 1'b0; d_wdata = 32'd0; d_wstrb = 4'd0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
      glog = "";
      repeat (2) @(negedge clk);
      #1;
      chk1("rst_bus_req", bus_req, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_i_rvalid", i_rvalid, 1'b0);
      chk1("rst_d_rvalid", d_rvalid, 1'b0);
      chk1("rst_bus_we", bus_we, 1'b0);
      chk32("rst_bus_addr", bus_addr, 32'd0);
      chk32("rst_bus_wdata", bus_wdata, 32'd0);
      chk32("rst_i_rdata", i_rdata, 32'd0);
      chk32("rst_d_rdata", d_rdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single fetch with immediate bus grant and response.
      i_req = 1'b1; i_addr = 32'h0000_0100;
      #1; chk1("s1_i_gnt", i_gnt, 1'b1);
      step();
      i_req = 1'b0; i_addr = 32'hFFFF_FFFF; bus_gnt = 1'b1;
      #1; chk1("s1_bus_req", bus_req, 1'b1); chk32("s1_bus_addr", bus_addr, 32'h0000_0100);
      step();
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0013;
      step();
      bus_rvalid = 1'b0;
      #1; chk1("s1_i_rvalid", i_rvalid, 1'b1); chk32("s1_i_rdata", i_rdata, 32'h0000_0013);
      step();
      #1; chk1("s1_i_rvalid_pulse", i_rvalid, 1'b0);
      step();

      // Data write with the bus grant withheld three cycles.
      d_req = 1'b1; d_addr = 32'h0000_2000; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
      #1; chk1("s2_d_gnt", d_gnt, 1'b1);
      step();
      d_req = 1'b0; d_addr = 32'h5555_5555; d_we = 1'b0; d_wdata = 32'd0; d_wstrb = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk1("s2_bus_req", bus_req, 1'b1);
         chk32("s2_bus_addr", bus_addr, 32'h0000_2000);
         chk32("s2_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
         chk32("s2_bus_wstrb", {28'd0, bus_wstrb}, 32'd3);
         chk1("s2_bus_we", bus_we, 1'b1);
         step();
      end
      bus_gnt = 1'b1; step();
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = $urandom; step();
      bus_rvalid = 1'b0;
      #1; chk1("s2_d_rvalid", d_rvalid, 1'b1);
      step();
      #1; chk1("s2_d_rvalid_pulse", d_rvalid, 1'b0);
      step();

      // Both ports saturated: fetch gets every fifth grant.
      glog = ""; i_req = 1'b1; i_addr = 32'h0000_1000; d_req = 1'b1; d_we = 1'b0;
      d_addr = 32'h0000_3000; bus_gnt = 1'b1; bus_rvalid = 1'b1;
      for (int k = 0; k < 60 && glog.len() < 10; k++) step();
      n_tests++;
      if (glog != "DDDDIDDDDI") begin
         n_fail++;
         $display("FAIL s3_order: got %s expected DDDDIDDDDI", glog);
      end
      i_req = 1'b0; d_req = 1'b0;
      repeat (4) step();
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      step();

      // Flush in WAIT_RSP hides the fetch response; data is granted right after.
      i_req = 1'b1; i_addr = 32'h0000_0300; step();
      i_req = 1'b0; bus_gnt = 1'b1; step();
      bus_gnt = 1'b0; i_flush = 1'b1; step();
      i_flush = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000_1234; step();
      bus_rvalid = 1'b0; d_req = 1'b1; d_addr = 32'h0000_0400; d_we = 1'b0;
      #1; chk1("s4_i_rvalid", i_rvalid, 1'b0); chk1("s4_d_gnt", d_gnt, 1'b1);
      step();
      d_req = 1'b0; bus_gnt = 1'b1; step();
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000_5678; step();
      bus_rvalid = 1'b0; step();

      // New data grant in the same cycle as the fetch's rvalid pulse.
      i_req = 1'b1; i_addr = 32'h0000_0500; step();
      i_req = 1'b0; bus_gnt = 1'b1; step();
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000_CAFE; step();
      bus_rvalid = 1'b0; d_req = 1'b1; d_addr = 32'h0000_0600;
      #1; chk1("s5_i_rvalid", i_rvalid, 1'b1); chk1("s5_d_gnt", d_gnt, 1'b1);
      step();
      d_req = 1'b0; bus_gnt = 1'b1; bus_rvalid = 1'b1;
      repeat (3) step();
      bus_gnt = 1'b0; bus_rvalid = 1'b0; step();

      // Reset one cycle after bus_req rises abandons the transaction.
      i_req = 1'b1; i_addr = 32'h0000_0700; step();
      i_req = 1'b0; step();
      rst = 1'b1; step();
      rst = 1'b0; bus_rvalid = 1'b1;
      #1; chk1("s6_bus_req", bus_req, 1'b0); chk1("s6_busy", busy, 1'b0);
      step();
      bus_gnt = 1'b1;
      repeat (3) begin
         #1; chk1("s6_no_i_rvalid", i_rvalid, 1'b0); chk1("s6_no_d_rvalid", d_rvalid, 1'b0);
         step();
      end
      bus_gnt = 1'b0; bus_rvalid = 1'b0; step();

      // Randomized traffic; requesters hold their fields until granted.
      for (int c = 0; c < 4000; c++) begin
         if (e_ig || !i_req) begin
            i_req  = ($urandom_range(0, 2) != 0);
            i_addr = $urandom;
         end
         if (e_dg || !d_req) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_addr  = $urandom;
            d_we    = ($urandom_range(0, 1) != 0);
            d_wdata = $urandom;
            d_wstrb = 4'($urandom);
         end
         i_flush    = ($urandom_range(0, 9) == 0);
         bus_gnt    = ($urandom_range(0, 1) != 0);
         bus_rvalid = ($urandom_range(0, 2) == 0);
         bus_rdata  = $urandom;
         rst        = ($urandom_range(0, 199) == 0);
         step();
      end

      rst = 1'b0; i_req = 1'b0; d_req = 1'b0; i_flush = 1'b0;
      bus_gnt = 1'b1; bus_rvalid = 1'b1;
      repeat (4) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
